// File: rtl/laser_rate_pkg.sv
// laser_rate_pkg: shared types and constants for the laser repetition-rate meter.
// Holds the main FSM state enum, default gate/counter sizing and the glitch
// filter length used when LASER_RATE_FILTER_EN is defined.
package laser_rate_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int GATE_CYCLES_DEFAULT = 50_000_000;
    localparam int CNT_WIDTH_DEFAULT   = 32;
    localparam int FILTER_LEN          = 4;
    localparam int RATE_WIDTH          = 32;

endpackage

// File: rtl/laser_rate_meter_if.sv
// laser_rate_meter_if: published-rate bus between the meter and its consumer
// (the Ethernet socket FSM). The consumer raises Hold to freeze LaserRate
// while it reads the word as two 16-bit halves.
interface laser_rate_meter_if;
    import laser_rate_pkg::*;

    logic [RATE_WIDTH-1:0] LaserRate;
    logic                  RateValid;
    logic                  Overflow;
    logic                  Hold;

    modport master (
        output LaserRate,
        output RateValid,
        output Overflow,
        input  Hold
    );

    modport slave (
        input  LaserRate,
        input  RateValid,
        input  Overflow,
        output Hold
    );

endinterface

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge: brings an asynchronous level into the Clk domain and
// produces a one-cycle strobe on each rising edge. Edge is a decode of
// registered state, so a rising Din is counted on the third Clk edge.
// Optional macro LASER_RATE_FILTER_EN inserts a glitch filter that only
// accepts a new level after it has been stable for FILTER_LEN cycles.
module pulse_sync_edge
    import laser_rate_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic Din,
    output logic Edge
);

    logic SyncMeta;
    logic SyncOut;
    logic Level;
    logic LevelPrev;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            SyncMeta <= 1'b0;
            SyncOut  <= 1'b0;
        end else begin
            SyncMeta <= Din;
            SyncOut  <= SyncMeta;
        end
    end

`ifdef LASER_RATE_FILTER_EN
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [FW-1:0] StableCnt;
    logic          FiltLevel;

    // Glitch filter: flip the accepted level once the synced input has disagreed for FILTER_LEN cycles in a row.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            StableCnt <= '0;
            FiltLevel <= 1'b0;
        end else if (SyncOut != FiltLevel) begin
            if (StableCnt == FW'(FILTER_LEN - 1)) begin
                FiltLevel <= SyncOut;
                StableCnt <= '0;
            end else begin
                StableCnt <= StableCnt + FW'(1);
            end
        end else begin
            StableCnt <= '0;
        end
    end

    assign Level = FiltLevel;
`else
    assign Level = SyncOut;
`endif

    // Edge register: remember the previous level so a rise can be decoded.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            LevelPrev <= 1'b0;
        end else begin
            LevelPrev <= Level;
        end
    end

    assign Edge = Level & ~LevelPrev;

endmodule

// File: rtl/laser_rate_meter.sv
// laser_rate_meter: counts laser trigger rising edges over a fixed gate window
// of GATE_CYCLES clocks and publishes the count as a 32-bit word. A Hold
// request from the consumer defers publishing into a pending register
// (newest window wins) so the word never changes mid-read.
// Optional macro LASER_RATE_FILTER_EN enables the input glitch filter inside
// pulse_sync_edge.
module laser_rate_meter
    import laser_rate_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               LaserPulse,
    input  logic               Enable,
    laser_rate_meter_if.master RateBus
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_t               State;
    state_t               StateNext;
    logic                 GateEnd;
    logic                 Running;
    logic                 PulseEdge;

    logic [GW-1:0]        GateCnt;
    logic [CNT_WIDTH-1:0] PulseCnt;
    logic                 WinOvf;
    logic                 CntAtMax;

    logic [CNT_WIDTH-1:0] SnapVal;
    logic                 SnapOvf;

    logic [CNT_WIDTH-1:0] Pending;
    logic                 PendOvf;
    logic                 PendFlag;

    pulse_sync_edge u_pulse_sync_edge (
        .Clk  (Clk),
        .Rst  (Rst),
        .Din  (LaserPulse),
        .Edge (PulseEdge)
    );

    // The gate-end snapshot folds in an edge arriving in the closing cycle, saturating like the counter does.
    assign CntAtMax = (PulseCnt == CNT_MAX);
    assign SnapVal  = (PulseEdge && !CntAtMax) ? (PulseCnt + CNT_WIDTH'(1)) : PulseCnt;
    assign SnapOvf  = WinOvf | (PulseEdge & CntAtMax);
    assign Running  = (State == RUN) && Enable;

    // FSM state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            State <= IDLE;
        end else begin
            State <= StateNext;
        end
    end

    // Next-state decode and gate-end detection; leaving RUN discards the partial window.
    always_comb begin
        StateNext = State;
        GateEnd   = 1'b0;
        case (State)
            IDLE: begin
                if (Enable) begin
                    StateNext = RUN;
                end
            end
            RUN: begin
                if (!Enable) begin
                    StateNext = IDLE;
                end else if (GateCnt == GATE_LAST) begin
                    GateEnd = 1'b1;
                end
            end
            default: begin
                StateNext = IDLE;
            end
        endcase
    end

    // Gate and pulse counters: back-to-back windows while running, held at zero otherwise.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            GateCnt  <= '0;
            PulseCnt <= '0;
            WinOvf   <= 1'b0;
        end else if (Running) begin
            if (GateEnd) begin
                GateCnt  <= '0;
                PulseCnt <= '0;
                WinOvf   <= 1'b0;
            end else begin
                GateCnt <= GateCnt + GW'(1);
                if (PulseEdge) begin
                    if (CntAtMax) begin
                        WinOvf <= 1'b1;
                    end else begin
                        PulseCnt <= PulseCnt + CNT_WIDTH'(1);
                    end
                end
            end
        end else begin
            GateCnt  <= '0;
            PulseCnt <= '0;
            WinOvf   <= 1'b0;
        end
    end

    // Publish path: fresh snapshot beats a pending one, Hold parks it, releasing Hold flushes the parked value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            RateBus.LaserRate <= '0;
            RateBus.RateValid <= 1'b0;
            RateBus.Overflow  <= 1'b0;
            Pending           <= '0;
            PendOvf           <= 1'b0;
            PendFlag          <= 1'b0;
        end else begin
            RateBus.RateValid <= 1'b0;
            if (GateEnd) begin
                if (RateBus.Hold) begin
                    Pending  <= SnapVal;
                    PendOvf  <= SnapOvf;
                    PendFlag <= 1'b1;
                end else begin
                    RateBus.LaserRate <= RATE_WIDTH'(SnapVal);
                    RateBus.Overflow  <= SnapOvf;
                    RateBus.RateValid <= 1'b1;
                    PendFlag          <= 1'b0;
                end
            end else if (!Running) begin
                PendFlag <= 1'b0;
            end else if (PendFlag && !RateBus.Hold) begin
                RateBus.LaserRate <= RATE_WIDTH'(Pending);
                RateBus.Overflow  <= PendOvf;
                RateBus.RateValid <= 1'b1;
                PendFlag          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_laser_rate_meter.sv
// tb_laser_rate_meter: directed bench for laser_rate_meter with a 100-cycle
// gate. A 32-bit instance covers publish timing, Hold deferral and reset; a
// 4-bit instance covers counter saturation. Expected values that depend on
// LASER_RATE_FILTER_EN are selected with the same macro.
`timescale 1ns/1ps
module tb_laser_rate_meter;
    import laser_rate_pkg::*;

    localparam int GATE = 100;

`ifdef LASER_RATE_FILTER_EN
    localparam logic [31:0] FAST_EXP = 32'd0;
    localparam logic [31:0] SAT_EXP  = 32'd0;
    localparam logic [31:0] SAT_OVF  = 32'd0;
`else
    localparam logic [31:0] FAST_EXP = 32'd50;
    localparam logic [31:0] SAT_EXP  = 32'd15;
    localparam logic [31:0] SAT_OVF  = 32'd1;
`endif

    logic Clk         = 1'b0;
    logic Rst         = 1'b0;
    logic LaserPulse  = 1'b0;
    logic Enable      = 1'b0;
    logic LaserPulse4 = 1'b0;
    logic Enable4     = 1'b0;

    int pos         = 0;
    int testsRun    = 0;
    int testsFailed = 0;

    laser_rate_meter_if rate_bus();
    laser_rate_meter_if rate_bus4();

    laser_rate_meter #(
        .GATE_CYCLES (GATE),
        .CNT_WIDTH   (32)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .LaserPulse (LaserPulse),
        .Enable     (Enable),
        .RateBus    (rate_bus)
    );

    laser_rate_meter #(
        .GATE_CYCLES (GATE),
        .CNT_WIDTH   (4)
    ) dut4 (
        .Clk        (Clk),
        .Rst        (Rst),
        .LaserPulse (LaserPulse4),
        .Enable     (Enable4),
        .RateBus    (rate_bus4)
    );

    always #5 Clk = ~Clk;

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
        pos += n;
    endtask

    task automatic waitUntil(input int target);
        if (target > pos) tick(target - pos);
    endtask

    // Drive count pulses of hiCycles high / loCycles low onto the selected instance.
    task automatic applyStimulus(input int count, input int hiCycles, input int loCycles, input bit toSmall);
        for (int i = 0; i < count; i++) begin
            if (toSmall) LaserPulse4 = 1'b1; else LaserPulse = 1'b1;
            tick(hiCycles);
            if (toSmall) LaserPulse4 = 1'b0; else LaserPulse = 1'b0;
            tick(loCycles);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rate_bus.Hold  = 1'b0;
        rate_bus4.Hold = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("reset_rate",   rate_bus.LaserRate, 32'd0);
        checkOutput("reset_valid",  32'(rate_bus.RateValid), 32'd0);
        checkOutput("reset_ovf",    32'(rate_bus.Overflow), 32'd0);
        checkOutput("reset_rate4",  rate_bus4.LaserRate, 32'd0);
        tick(3);
        Rst    = 1'b0;
        Enable = 1'b1;
        tick(1);
        pos = 0;

        // Ten 4/4 pulses in the first window.
        applyStimulus(10, 4, 4, 1'b0);
        waitUntil(99);
        checkOutput("t1_valid_early", 32'(rate_bus.RateValid), 32'd0);
        waitUntil(100);
        checkOutput("t1_valid", 32'(rate_bus.RateValid), 32'd1);
        checkOutput("t1_rate",  rate_bus.LaserRate, 32'd10);
        checkOutput("t1_ovf",   32'(rate_bus.Overflow), 32'd0);
        tick(1);
        checkOutput("t1_valid_once", 32'(rate_bus.RateValid), 32'd0);

        // Empty second window, then a Clk/2 toggle covering the whole third window.
        waitUntil(198);
        applyStimulus(1, 1, 1, 1'b0);
        checkOutput("t2_empty_valid", 32'(rate_bus.RateValid), 32'd1);
        checkOutput("t2_empty_rate",  rate_bus.LaserRate, 32'd0);
        applyStimulus(49, 1, 1, 1'b0);
        waitUntil(300);
        checkOutput("t2_fast_valid", 32'(rate_bus.RateValid), 32'd1);
        checkOutput("t2_fast_rate",  rate_bus.LaserRate, FAST_EXP);

        // Hold across one gate end with a count of 7.
        applyStimulus(7, 4, 4, 1'b0);
        waitUntil(390);
        rate_bus.Hold = 1'b1;
        waitUntil(400);
        checkOutput("t3_held_valid", 32'(rate_bus.RateValid), 32'd0);
        checkOutput("t3_held_rate",  rate_bus.LaserRate, FAST_EXP);
        waitUntil(410);
        rate_bus.Hold = 1'b0;
        tick(1);
        checkOutput("t3_release_valid", 32'(rate_bus.RateValid), 32'd1);
        checkOutput("t3_release_rate",  rate_bus.LaserRate, 32'd7);
        tick(1);
        checkOutput("t3_valid_once", 32'(rate_bus.RateValid), 32'd0);

        // Hold across two gate ends (7 then 12): only the newest is published.
        applyStimulus(7, 4, 4, 1'b0);
        waitUntil(470);
        rate_bus.Hold = 1'b1;
        waitUntil(500);
        checkOutput("t4_held1_valid", 32'(rate_bus.RateValid), 32'd0);
        checkOutput("t4_held1_rate",  rate_bus.LaserRate, 32'd7);
        applyStimulus(12, 4, 4, 1'b0);
        waitUntil(600);
        checkOutput("t4_held2_valid", 32'(rate_bus.RateValid), 32'd0);
        checkOutput("t4_held2_rate",  rate_bus.LaserRate, 32'd7);
        waitUntil(610);
        rate_bus.Hold = 1'b0;
        tick(1);
        checkOutput("t4_release_valid", 32'(rate_bus.RateValid), 32'd1);
        checkOutput("t4_release_rate",  rate_bus.LaserRate, 32'd12);
        tick(1);
        checkOutput("t4_single_publish", 32'(rate_bus.RateValid), 32'd0);

        // Publish 10, then reset mid-window at GateCnt = 50.
        applyStimulus(10, 4, 4, 1'b0);
        waitUntil(700);
        checkOutput("t6_pre_rate", rate_bus.LaserRate, 32'd10);
        waitUntil(750);
        Rst = 1'b1;
        #1;
        checkOutput("t6_reset_rate",  rate_bus.LaserRate, 32'd0);
        checkOutput("t6_reset_valid", 32'(rate_bus.RateValid), 32'd0);
        checkOutput("t6_reset_ovf",   32'(rate_bus.Overflow), 32'd0);
        tick(2);
        Rst = 1'b0;
        tick(1);
        pos = 0;
        applyStimulus(5, 4, 4, 1'b0);
        waitUntil(99);
        checkOutput("t6_no_early_valid", 32'(rate_bus.RateValid), 32'd0);
        checkOutput("t6_no_early_rate",  rate_bus.LaserRate, 32'd0);
        waitUntil(100);
        checkOutput("t6_first_valid", 32'(rate_bus.RateValid), 32'd1);
        checkOutput("t6_first_rate",  rate_bus.LaserRate, 32'd5);

        // 4-bit counter: 20 pulses saturate, then 3 pulses clear the overflow.
        Enable4 = 1'b1;
        tick(1);
        pos = 0;
        applyStimulus(20, 2, 2, 1'b1);
        waitUntil(100);
        checkOutput("t5_sat_valid", 32'(rate_bus4.RateValid), 32'd1);
        checkOutput("t5_sat_rate",  rate_bus4.LaserRate, SAT_EXP);
        checkOutput("t5_sat_ovf",   32'(rate_bus4.Overflow), SAT_OVF);
        applyStimulus(3, 4, 4, 1'b1);
        waitUntil(200);
        checkOutput("t5_next_valid", 32'(rate_bus4.RateValid), 32'd1);
        checkOutput("t5_next_rate",  rate_bus4.LaserRate, 32'd3);
        checkOutput("t5_next_ovf",   32'(rate_bus4.Overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
